// File: rtl/alu_cmd_parser.sv
// alu_cmd_parser: parses "<A><op><B>=" ASCII commands into ALU operands and returns the captured result.
// Optional byte echo is enabled by defining ALU_CMD_ECHO_EN.
module alu_cmd_parser #(
    parameter int          MAX_DIGITS = 3,
    parameter logic [7:0]  TERM_CHAR  = 8'h3D
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [10:0] alu_op_code,
    input  logic [7:0]  alu_out,
    input  logic [2:0]  alu_rem,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [7:0]  res_out,
    output logic [2:0]  res_rem,
    output logic        res_err,
    output logic [7:0]  echo_data,
    output logic        echo_valid
);
    typedef enum logic [1:0] {A_DIG, B_DIG, EXEC, RESULT} state_t;
    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam logic [7:0] ESC = 8'h1B, SPACE = 8'h20, CR = 8'h0D;

    state_t         state, state_n;
    logic [7:0]     acc, acc_n, a_n, b_n, ro_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic           err, err_n, rv_n, re_n;
    logic [10:0]    op_n, op_sel;
    logic [2:0]     rr_n;
    logic [11:0]    prod;
    logic           take, is_dig, is_op, is_term, cnt_full, bad;

    assign rx_ready = (state == A_DIG) || (state == B_DIG);
    assign take     = rx_valid && rx_ready;
    assign is_dig   = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    // Wider than the 8-bit accumulator so any overflow is visible before truncation.
    assign prod     = {4'd0, acc} * 12'd10 + {8'd0, rx_data[3:0]};
    assign op_sel   = rx_data == 8'h2B ? 11'h001 :
                      rx_data == 8'h2D ? 11'h002 :
                      rx_data == 8'h2A ? 11'h004 :
                      rx_data == 8'h2F ? 11'h008 : 11'h000;
    assign is_op    = op_sel != 11'h000;
    assign is_term  = (rx_data == TERM_CHAR) || (rx_data == CR);
    assign cnt_full = cnt == CW'(MAX_DIGITS);
    assign bad      = err || (alu_op_code[3] && alu_b == 8'd0);

    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt;
        err_n   = err;
        a_n     = alu_a;
        b_n     = alu_b;
        op_n    = alu_op_code;
        rv_n    = res_valid;
        ro_n    = res_out;
        rr_n    = res_rem;
        re_n    = res_err;
        case (state)
            A_DIG, B_DIG: begin
                if (take) begin
                    if (rx_data == ESC) begin
                        acc_n   = 8'd0;
                        cnt_n   = '0;
                        err_n   = 1'b0;
                        op_n    = 11'h000;
                        state_n = A_DIG;
                    end else if (rx_data == SPACE) begin
                    end else if (is_dig) begin
                        acc_n = prod[7:0];
                        cnt_n = cnt_full ? cnt : cnt + CW'(1);
                        err_n = err || cnt_full || (prod > 12'd255);
                    end else if (is_op && state == A_DIG) begin
                        if (cnt != '0) begin
                            a_n     = acc;
                            op_n    = op_sel;
                            acc_n   = 8'd0;
                            cnt_n   = '0;
                            state_n = B_DIG;
                        end else begin
                            err_n = 1'b1;
                        end
                    end else if (is_term) begin
                        err_n   = err || (cnt == '0) || (state == A_DIG);
                        b_n     = (state == B_DIG && cnt != '0) ? acc : alu_b;
                        state_n = EXEC;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            EXEC: begin
                ro_n    = bad ? 8'd0 : alu_out;
                rr_n    = bad ? 3'd0 : alu_rem;
                re_n    = bad;
                rv_n    = 1'b1;
                state_n = RESULT;
            end
            RESULT: begin
                if (res_ready) begin
                    rv_n    = 1'b0;
                    acc_n   = 8'd0;
                    cnt_n   = '0;
                    err_n   = 1'b0;
                    op_n    = 11'h000;
                    state_n = A_DIG;
                end
            end
            default: state_n = A_DIG;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= A_DIG;
            acc         <= 8'd0;
            cnt         <= '0;
            err         <= 1'b0;
            alu_a       <= 8'd0;
            alu_b       <= 8'd0;
            alu_op_code <= 11'h000;
            res_valid   <= 1'b0;
            res_out     <= 8'd0;
            res_rem     <= 3'd0;
            res_err     <= 1'b0;
        end else begin
            state       <= state_n;
            acc         <= acc_n;
            cnt         <= cnt_n;
            err         <= err_n;
            alu_a       <= a_n;
            alu_b       <= b_n;
            alu_op_code <= op_n;
            res_valid   <= rv_n;
            res_out     <= ro_n;
            res_rem     <= rr_n;
            res_err     <= re_n;
        end
    end

`ifdef ALU_CMD_ECHO_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo_data  <= 8'd0;
            echo_valid <= 1'b0;
        end else begin
            echo_valid <= take && rx_data != ESC;
            echo_data  <= (take && rx_data != ESC) ? rx_data : echo_data;
        end
    end
`else
    assign echo_data  = 8'd0;
    assign echo_valid = 1'b0;
`endif
endmodule

// File: tb/tb_alu_cmd_parser.sv
// tb_alu_cmd_parser: directed self-checking bench for alu_cmd_parser with a behavioural ALU model.
module tb_alu_cmd_parser;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  alu_a, alu_b, alu_out, res_out, echo_data;
    logic [10:0] alu_op_code;
    logic [2:0]  alu_rem, res_rem;
    logic        res_valid, res_err, echo_valid;
    logic        res_ready = 1'b0;
    int          tests = 0;
    int          fails = 0;
    logic [15:0] prod16;
    logic [7:0]  quo, modv;

    alu_cmd_parser dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op_code(alu_op_code), .alu_out(alu_out), .alu_rem(alu_rem),
        .res_valid(res_valid), .res_ready(res_ready), .res_out(res_out), .res_rem(res_rem),
        .res_err(res_err), .echo_data(echo_data), .echo_valid(echo_valid)
    );

    always #5 clk = ~clk;

    // Reference ALU: add, absolute difference, low byte of product, quotient/remainder.
    always_comb begin
        prod16  = {8'd0, alu_a} * {8'd0, alu_b};
        quo     = alu_b == 8'd0 ? 8'hFF : alu_a / alu_b;
        modv    = alu_b == 8'd0 ? 8'h07 : alu_a % alu_b;
        alu_out = alu_op_code[0] ? alu_a + alu_b :
                  alu_op_code[1] ? (alu_a >= alu_b ? alu_a - alu_b : alu_b - alu_a) :
                  alu_op_code[2] ? prod16[7:0] :
                  alu_op_code[3] ? quo : 8'd0;
        alu_rem = alu_op_code[3] ? modv[2:0] : 3'd0;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic wait_res(input string tag);
        for (int i = 0; i < 10 && !res_valid; i++) begin
            @(posedge clk);
            #1;
        end
        chk({tag, " valid"}, 16'(res_valid), 16'd1);
    endtask

    task automatic consume();
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
    endtask

    task automatic run_cmd(input string s, input logic [7:0] eo, input logic [2:0] er, input logic ee);
        send_str(s);
        wait_res(s);
        chk({s, " out"}, 16'(res_out), 16'(eo));
        chk({s, " rem"}, 16'(res_rem), 16'(er));
        chk({s, " err"}, 16'(res_err), 16'(ee));
        consume();
        chk({s, " drop"}, 16'(res_valid), 16'd0);
    endtask

    initial begin
        #12;
        chk("rst rx_ready", 16'(rx_ready), 16'd1);
        chk("rst res_valid", 16'(res_valid), 16'd0);
        chk("rst op", 16'(alu_op_code), 16'd0);
        chk("rst a", 16'(alu_a), 16'd0);
        chk("rst b", 16'(alu_b), 16'd0);
        chk("rst out", 16'(res_out), 16'd0);
        chk("rst echo", 16'({echo_valid, echo_data}), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        send_str("12+34");
        chk("add op", 16'(alu_op_code), 16'h001);
        chk("add a", 16'(alu_a), 16'd12);
        send("=");
        chk("add b", 16'(alu_b), 16'd34);
        chk("add lat1", 16'(res_valid), 16'd0);
        chk("exec rx_ready", 16'(rx_ready), 16'd0);
        @(posedge clk);
        #1;
        chk("add lat2", 16'(res_valid), 16'd1);
        chk("add out", 16'(res_out), 16'd46);
        chk("add rem", 16'(res_rem), 16'd0);
        chk("add err", 16'(res_err), 16'd0);
        consume();
        chk("add op clr", 16'(alu_op_code), 16'd0);
        chk("add rx_ready back", 16'(rx_ready), 16'd1);

        send_str("200 - 50");
        chk("sub op", 16'(alu_op_code), 16'h002);
        run_cmd("\r", 8'd150, 3'd0, 1'b0);

        send_str("17/5");
        chk("div op", 16'(alu_op_code), 16'h008);
        run_cmd("=", 8'd3, 3'd2, 1'b0);
        run_cmd("7/0=", 8'd0, 3'd0, 1'b1);
        run_cmd("256+1=", 8'd0, 3'd0, 1'b1);
        run_cmd("1234+1=", 8'd0, 3'd0, 1'b1);
        run_cmd("+5=", 8'd0, 3'd0, 1'b1);
        run_cmd("255+0=", 8'd255, 3'd0, 1'b0);
        run_cmd("5-9=", 8'd4, 3'd0, 1'b0);

        send_str("9*");
        chk("esc pre op", 16'(alu_op_code), 16'h004);
        send(8'h1B);
        chk("esc op", 16'(alu_op_code), 16'd0);
        chk("esc no res", 16'(res_valid), 16'd0);
        send_str("3*4=");
        wait_res("mul");
        chk("mul op", 16'(alu_op_code), 16'h004);
        chk("mul out", 16'(res_out), 16'd12);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("hold out", 16'(res_out), 16'd12);
            chk("hold valid", 16'(res_valid), 16'd1);
            chk("hold rx_ready", 16'(rx_ready), 16'd0);
        end
        consume();

        send_str("12+3");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst a", 16'(alu_a), 16'd0);
        chk("arst op", 16'(alu_op_code), 16'd0);
        chk("arst rx_ready", 16'(rx_ready), 16'd1);
        chk("arst out", 16'(res_out), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_cmd("1+1=", 8'd2, 3'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
